// File: rtl/pwm_pkg.sv
// Shared definitions for the RGBW PWM frame scheduler.
package pwm_pkg;

    localparam int DEF_W    = 8;
    localparam int DEF_N_CH = 4;
    localparam int DEF_TOP  = 254;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic is_busy(state_t s);
        return (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/pwm_compare_ch.sv
// One PWM channel: registered unsigned cnt < duty compare, forced low when disabled.
module pwm_compare_ch #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] cnt,
    input  logic [W-1:0] duty,
    output logic         pwm
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm <= 1'b0;
        end else begin
            pwm <= en && (cnt < duty);
        end
    end

endmodule

// File: rtl/pwm_frame_scheduler.sv
// Frame sequencer: prescaler tick, frame counter, run/drain FSM and
// double-buffered duty registers that only change on frame boundaries.
module pwm_frame_scheduler
    import pwm_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int N_CH = DEF_N_CH,
    parameter int TOP  = DEF_TOP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_presc,
    input  logic              run,
    input  logic              upd_valid,
    input  logic [N_CH*W-1:0] upd_duty,
    output logic              upd_ready,
    output logic [N_CH-1:0]   pwm,
    output logic              frame_start,
    output logic              busy
);

    localparam logic [W-1:0] TOP_V = W'(TOP);

    state_t            state;
    state_t            state_n;
    logic              presc_q;
    logic              tick;
    logic              wrap;
    logic              apply;
    logic              xfer;
    logic              fs_n;
    logic [W-1:0]      cnt;
    logic [W-1:0]      cnt_n;
    logic [N_CH*W-1:0] duty_act;
    logic [N_CH*W-1:0] shadow;
    logic              shadow_full;

    assign tick      = clk_presc & ~presc_q;
    assign wrap      = tick && (cnt == TOP_V);
    assign busy      = is_busy(state);
    assign upd_ready = ~shadow_full;
    assign xfer      = upd_valid & upd_ready;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        fs_n    = 1'b0;
        apply   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (run) begin
                    state_n = ST_RUN;
                    fs_n    = 1'b1;
                    apply   = 1'b1;
                end
            end
            ST_RUN: begin
                if (tick) cnt_n = wrap ? '0 : cnt + 1'b1;
                if (wrap) begin
                    fs_n  = 1'b1;
                    apply = 1'b1;
                end
                if (!run) state_n = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (tick) cnt_n = wrap ? '0 : cnt + 1'b1;
                // The drain frame always completes; run is only sampled at its wrap.
                if (wrap) begin
                    apply = 1'b1;
                    if (run) begin
                        state_n = ST_RUN;
                        fs_n    = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            presc_q     <= 1'b0;
            frame_start <= 1'b0;
            duty_act    <= '0;
            shadow      <= '0;
            shadow_full <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            presc_q     <= clk_presc;
            frame_start <= fs_n;
            // A transfer can only happen with the shadow empty, so the two never collide.
            if (apply && shadow_full) begin
                duty_act    <= shadow;
                shadow_full <= 1'b0;
            end else if (xfer) begin
                shadow      <= upd_duty;
                shadow_full <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pwm_compare_ch #(.W(W)) u_ch (
            .clk   (clk),
            .reset (reset),
            .en    (busy),
            .cnt   (cnt),
            .duty  (duty_act[i*W +: W]),
            .pwm   (pwm[i])
        );
    end

endmodule

// File: tb/tb_pwm_frame_scheduler.sv
// Bench for pwm_frame_scheduler: directed scenarios plus random traffic vs a behavioural model.
module tb_pwm_frame_scheduler;
    import pwm_pkg::*;

    localparam int W   = DEF_W;
    localparam int N   = DEF_N_CH;
    localparam int TOP = DEF_TOP;

    logic           clk = 1'b0;
    logic           reset;
    logic           clk_presc;
    logic           run;
    logic           upd_valid;
    logic [N*W-1:0] upd_duty;
    logic           upd_ready;
    logic [N-1:0]   pwm;
    logic           frame_start;
    logic           busy;

    int checks = 0;
    int errors = 0;

    // behavioural model: on/stopping flags, frame position, applied and pending duty sets
    bit           m_prev, m_on, m_stop, m_pend, m_fs;
    int           m_cnt;
    int           m_duty[N];
    int           m_pval[N];
    logic [N-1:0] m_pwm;

    always #5 clk = ~clk;

    pwm_frame_scheduler u_dut (
        .clk         (clk),
        .reset       (reset),
        .clk_presc   (clk_presc),
        .run         (run),
        .upd_valid   (upd_valid),
        .upd_duty    (upd_duty),
        .upd_ready   (upd_ready),
        .pwm         (pwm),
        .frame_start (frame_start),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] pack_duty();
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(m_duty[i]);
        return r;
    endfunction

    task automatic model_reset();
        m_prev = 0; m_on = 0; m_stop = 0; m_pend = 0; m_fs = 0;
        m_cnt = 0; m_pwm = '0;
        for (int i = 0; i < N; i++) begin
            m_duty[i] = 0;
            m_pval[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit tick, fend, bnd, xfer;
        logic [N-1:0] np;
        tick   = clk_presc && !m_prev;
        m_prev = clk_presc;
        for (int i = 0; i < N; i++) np[i] = m_on && (m_cnt < m_duty[i]);
        xfer = upd_valid && !m_pend;
        fend = m_on && tick && (m_cnt == TOP);
        bnd  = 0;
        m_fs = 0;
        if (!m_on) begin
            if (run) begin
                m_on = 1; m_stop = 0; m_fs = 1; bnd = 1;
            end
        end else begin
            if (tick) m_cnt = (m_cnt + 1) % (TOP + 1);
            if (fend) begin
                bnd = 1;
                if (m_stop && !run) begin
                    m_on = 0;
                end else begin
                    m_fs = 1;
                    m_stop = !run;
                end
            end else if (!run) begin
                m_stop = 1;
            end
        end
        if (bnd && m_pend) begin
            for (int i = 0; i < N; i++) m_duty[i] = m_pval[i];
            m_pend = 0;
        end else if (xfer) begin
            for (int i = 0; i < N; i++) m_pval[i] = int'(upd_duty[i*W +: W]);
            m_pend = 1;
        end
        m_pwm = np;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        @(negedge clk);
        check("pwm", 64'(pwm), 64'(m_pwm));
        check("frame_start", 64'(frame_start), 64'(m_fs));
        check("busy", 64'(busy), 64'(m_on));
        check("upd_ready", 64'(upd_ready), 64'(!m_pend));
        check("cnt", 64'(u_dut.cnt), 64'(m_cnt));
        check("duty_act", 64'(u_dut.duty_act), 64'(pack_duty()));
    endtask

    task automatic tog();
        clk_presc = ~clk_presc;
        step();
    endtask

    function automatic logic [N*W-1:0] rnd_duty();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 5))
                0: r[i*W +: W] = 8'd0;
                1: r[i*W +: W] = 8'd1;
                2: r[i*W +: W] = 8'd254;
                3: r[i*W +: W] = 8'd255;
                default: r[i*W +: W] = W'($urandom_range(0, 255));
            endcase
        end
        return r;
    endfunction

    initial begin
        int nfs;
        int c0;
        int cnt_hi[N];
        logic [N*W-1:0] old;
        bit seen;

        reset = 1'b1; clk_presc = 1'b0; run = 1'b0;
        upd_valid = 1'b0; upd_duty = '0;
        model_reset();
        repeat (2) step();
        reset = 1'b0;
        step();

        // duty apply on IDLE->RUN entry
        upd_duty  = {8'd0, 8'd255, 8'd1, 8'd128};
        upd_valid = 1'b1;
        step();
        upd_valid = 1'b0;
        check("s2_ready_low", 64'(upd_ready), 0);
        run = 1'b1;
        step();
        check("s2_entry_fs", 64'(frame_start), 1);
        check("s2_entry_duty", 64'(u_dut.duty_act), 64'h00FF0180);
        nfs = 0;
        for (int k = 0; k < 1200 && nfs == 0; k++) begin
            tog();
            if (frame_start) nfs++;
        end
        check("s2_wrap_seen", 64'(nfs), 1);
        nfs = 0;
        for (int i = 0; i < N; i++) cnt_hi[i] = 0;
        for (int k = 0; k < 2 * (TOP + 1); k++) begin
            tog();
            for (int i = 0; i < N; i++) cnt_hi[i] += int'(pwm[i]);
            if (frame_start) nfs++;
        end
        check("s2_ch0_hi", 64'(cnt_hi[0]), 256);
        check("s2_ch1_hi", 64'(cnt_hi[1]), 2);
        check("s2_ch2_hi", 64'(cnt_hi[2]), 510);
        check("s2_ch3_hi", 64'(cnt_hi[3]), 0);
        check("s2_fs_per_frame", 64'(nfs), 1);
        check("s2_fs_period", 64'(frame_start), 1);

        // double buffer
        for (int k = 0; k < 1200 && m_cnt != 10; k++) tog();
        check("s3_at10", 64'(m_cnt), 10);
        upd_duty  = {8'd0, 8'd255, 8'd1, 8'd20};
        upd_valid = 1'b1;
        step();
        check("s3_ready_after_wr", 64'(upd_ready), 0);
        upd_duty = {8'd0, 8'd255, 8'd1, 8'd30};
        step();
        check("s3_r_not_yet", 64'(u_dut.duty_act[7:0]), 128);
        seen = 0;
        for (int k = 0; k < 1200 && !seen; k++) begin
            tog();
            seen = frame_start;
        end
        check("s3_wrap_seen", 64'(seen), 1);
        check("s3_r20", 64'(u_dut.duty_act[7:0]), 20);
        check("s3_ready_after_wrap", 64'(upd_ready), 1);
        tog();
        check("s3_r30_accepted", 64'(upd_ready), 0);
        upd_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 1200 && !seen; k++) begin
            tog();
            seen = frame_start;
        end
        check("s3_r30", 64'(u_dut.duty_act[7:0]), 30);

        // stop / drain
        for (int k = 0; k < 1200 && m_cnt != 100; k++) tog();
        run = 1'b0;
        tog();
        check("s4_busy_drain", 64'(busy), 1);
        for (int k = 0; k < 1200 && busy; k++) tog();
        check("s4_idle", 64'(busy), 0);
        tog();
        tog();
        check("s4_pwm_off", 64'(pwm), 0);
        run = 1'b1;
        step();
        for (int k = 0; k < 1200 && m_cnt != 50; k++) tog();
        run = 1'b0;
        tog();
        for (int k = 0; k < 1200 && m_cnt != 200; k++) tog();
        run = 1'b1;
        seen = 0;
        for (int k = 0; k < 1200 && !seen; k++) begin
            tog();
            seen = frame_start;
        end
        check("s4_resume_fs", 64'(seen), 1);
        check("s4_resume_state", 64'(u_dut.state), 64'(ST_RUN));

        // tick gating
        c0 = m_cnt;
        repeat (50) step();
        check("s5_hold_cnt", 64'(u_dut.cnt), 64'(c0));
        if (clk_presc) begin
            clk_presc = 1'b0;
            step();
        end
        c0 = m_cnt;
        clk_presc = 1'b1;
        step();
        step();
        step();
        check("s5_one_tick", 64'(u_dut.cnt), 64'((c0 + 1) % (TOP + 1)));

        // wrap and transfer in the same cycle
        for (int k = 0; k < 1200 && !(m_cnt == TOP && clk_presc); k++) tog();
        check("s6_at_top", 64'(m_cnt), 64'(TOP));
        old = pack_duty();
        clk_presc = 1'b0;
        step();
        clk_presc = 1'b1;
        upd_valid = 1'b1;
        upd_duty  = 32'h00FF01C8;
        step();
        upd_valid = 1'b0;
        check("s6_wrap_fs", 64'(frame_start), 1);
        check("s6_not_applied", 64'(u_dut.duty_act), 64'(old));
        check("s6_shadow_full", 64'(upd_ready), 0);
        seen = 0;
        for (int k = 0; k < 1200 && !seen; k++) begin
            tog();
            seen = frame_start;
        end
        check("s6_applied", 64'(u_dut.duty_act), 64'h00FF01C8);

        // async reset mid-frame with a pending shadow
        upd_valid = 1'b1;
        upd_duty  = 32'h11111111;
        step();
        upd_valid = 1'b0;
        for (int k = 0; k < 1200 && !pwm[0]; k++) tog();
        check("s1_pwm0_high", 64'(pwm[0]), 1);
        #2;
        reset = 1'b1;
        #1;
        check("s1_async_pwm", 64'(pwm), 0);
        check("s1_async_busy", 64'(busy), 0);
        check("s1_async_ready", 64'(upd_ready), 1);
        model_reset();
        step();
        reset = 1'b0;
        step();
        check("s1_cnt_after", 64'(u_dut.cnt), 0);
        check("s1_duty_cleared", 64'(u_dut.duty_act), 0);

        // random traffic
        for (int k = 0; k < 4000; k++) begin
            clk_presc = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) run = ~run;
            upd_valid = ($urandom_range(0, 3) == 0);
            upd_duty  = rnd_duty();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
